// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit scheduler.
// Optional feature macro: UART_TX_SCHED_TAG_EN adds the tag-frame states and
// the tag marker constant.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Upper bound on the number of requesters; also sizes the 4-bit tag id.
    localparam int MAX_REQ = 16;

`ifdef UART_TX_SCHED_TAG_EN
    // High nibble of the tag frame that precedes every data byte.
    localparam logic [3:0] TAG_MARK = 4'hF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_HI   = 3'd2,
        WAIT_LO   = 3'd3,
        TAG_START = 3'd4,
        TAG_HI    = 3'd5,
        TAG_LO    = 3'd6
    } sched_state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sched_state_t;
`endif

    // Index of the requester after idx, wrapping back to 0 after n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: returns the first asserted request
// at or after ptr_i, wrapping modulo N_REQ, as a one-hot vector plus its index.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    // Two ordered passes: first the indices at or above the pointer, then the
    // wrapped ones below it. The second pass only runs when the first found
    // nothing, so it can only ever pick an index below the pointer.
    // NOTE: every output gets a default before the loops so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_o && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                any_o       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_o && req_i[i]) begin
                any_o       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = IDX_W'(i);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one uart_tx serializer among N_REQ byte producers. One byte is taken
// per grant over valid/ready, launched with a one-cycle tx_start, and the
// serializer's busy is tracked high then low before the next grant.
// Optional feature macro: UART_TX_SCHED_TAG_EN -- each accepted byte is
// preceded by a tag frame {TAG_MARK, grant id}; DATA_WIDTH must then be 8.
// N_REQ is expected in the range 2..MAX_REQ.
// -----------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int GID_W      = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [15:0]                 prescale_cfg,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        tx_start,
    output logic [15:0]                 prescale,
    input  logic                        tx_busy,
    output logic [GID_W-1:0]            grant_id,
    output logic                        sched_busy
);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    sched_state_t          state_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_start_q;
    logic [15:0]           prescale_q;
    logic [GID_W-1:0]      grant_id_q;
    logic                  sched_busy_q;
    logic [GID_W-1:0]      rr_ptr_q;
    logic [GID_W-1:0]      rr_ptr_d;

`ifdef UART_TX_SCHED_TAG_EN
    localparam int TAG_ID_W = $clog2(MAX_REQ);

    // The data byte waits here while the tag frame goes out first.
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] tag_byte;
`endif

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0]      arb_grant;
    logic [GID_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  ready_window;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // Ready is offered only in IDLE and only while the serializer is quiet, so a
    // foreign driver holding busy high blocks every grant until it lets go.
    assign ready_window = (state_q == IDLE) && !tx_busy && arb_any;
    assign req_ready    = arb_grant & {N_REQ{ready_window}};
    assign accept       = |(req_valid & req_ready);

    // Pointer moves to the requester just after the winner, so the winner has
    // the lowest priority on the next round.
    assign rr_ptr_d = GID_W'(wrap_inc(int'(arb_idx), N_REQ));

`ifdef UART_TX_SCHED_TAG_EN
    assign tag_byte = DATA_WIDTH'({TAG_MARK, TAG_ID_W'(arb_idx)});
`endif

    // Byte of the granted requester; zero when nothing is granted.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scheduler FSM: acceptance, launch pulse, busy tracking, pointer update
    // -------------------------------------------------------------------------
    // Sequences acceptance, launch and busy tracking, and updates the pointer.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronous reset abandons any frame in flight.
            state_q      <= IDLE;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            prescale_q   <= '0;
            grant_id_q   <= '0;
            sched_busy_q <= 1'b0;
            rr_ptr_q     <= '0;
`ifdef UART_TX_SCHED_TAG_EN
            hold_q       <= '0;
`endif
        end else begin
            // The launch pulse is a single cycle unless a branch re-arms it.
            tx_start_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_id_q   <= arb_idx;
                        prescale_q   <= prescale_cfg;
                        rr_ptr_q     <= rr_ptr_d;
                        tx_start_q   <= 1'b1;
                        sched_busy_q <= 1'b1;
`ifdef UART_TX_SCHED_TAG_EN
                        tx_data_q    <= tag_byte;
                        hold_q       <= sel_data;
                        state_q      <= TAG_START;
`else
                        tx_data_q    <= sel_data;
                        state_q      <= START;
`endif
                    end
                end

                // Launch pulse is on the output during this cycle.
                START: begin
                    state_q <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (tx_busy) begin
                        state_q <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    if (!tx_busy) begin
                        state_q      <= IDLE;
                        sched_busy_q <= 1'b0;
                    end
                end

`ifdef UART_TX_SCHED_TAG_EN
                TAG_START: begin
                    state_q <= TAG_HI;
                end

                TAG_HI: begin
                    if (tx_busy) begin
                        state_q <= TAG_LO;
                    end
                end

                // Tag frame done: swap in the held byte and launch it with the
                // same prescale.
                TAG_LO: begin
                    if (!tx_busy) begin
                        tx_data_q  <= hold_q;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
`endif

                default: begin
                    state_q      <= IDLE;
                    sched_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign prescale   = prescale_q;
    assign grant_id   = grant_id_q;
    assign sched_busy = sched_busy_q;

endmodule : uart_tx_sched
